muldiv_seq: RTL and testbench

- Parametrised sequential multiply/divide unit with HI/LO result registers.
- Replaces the separate fixed 32-bit mult/div blocks and their external HI/LO source muxing in the multicycle CPU datapath.
- Handles signed and unsigned MULT/DIV through one start/busy/done handshake.
- The control FSM issues `start` with an opcode; operands come from the A/B registers; `hi`/`lo` feed the MemtoReg mux.

---
 rtl/muldiv_seq.sv | 256 +++++++++++++++++++++++++
 tb/tb_muldiv_seq.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_seq
//  Description : Sequential multiply / divide unit with HI/LO result registers.
//                Signed and unsigned MULT/DIV are handled through a single
//                start / busy / done handshake.
//                  - Multiply: radix-2 shift-add, one multiplier bit per cycle,
//                    over a 2*WIDTH accumulator.
//                  - Divide  : restoring division, one quotient bit per cycle,
//                    with a WIDTH+1 bit partial remainder.
//                Both operate on operand magnitudes. The final sign correction
//                is applied in a single FIX cycle, which is also the only
//                cycle (apart from reset) in which hi/lo are written.
//
//  Optional    : MULDIV_EARLY_OUT_EN
//                When defined, a multiply leaves RUN as soon as the remaining
//                unshifted multiplier magnitude is zero. FIX then aligns the
//                accumulator by the number of skipped steps. Divide timing is
//                not affected. Consumers must always wait for done.
//
//  Parameters  : WIDTH  operand / result-half width in bits (>= 4)
//                CNT_W  iteration counter width (derived from WIDTH)
//
//  Ports       : clk       in   1      system clock, rising edge
//                rst       in   1      asynchronous reset, active-high
//                start     in   1      request, sampled only in IDLE
//                op        in   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//                a         in   WIDTH  multiplicand / dividend
//                b         in   WIDTH  multiplier / divisor
//                busy      out  1      operation in progress
//                done      out  1      one-cycle completion pulse
//                div_zero  out  1      last accepted DIV/DIVU had b == 0
//                hi        out  WIDTH  MULT: upper product half, DIV: remainder
//                lo        out  WIDTH  MULT: lower product half, DIV: quotient
//
//  Revision    : 1.0  initial release
// ============================================================================

module muldiv_seq #(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_FIX  = 2'd2;

    // Counter value of the final RUN step.
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(WIDTH - 1);
`ifdef MULDIV_EARLY_OUT_EN
    localparam logic [CNT_W-1:0] c_CNT_FULL = CNT_W'(WIDTH);
`endif

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [1:0]         r_state;
    logic [1:0]         r_op;        // op[1]: divide, op[0]: unsigned
    logic [WIDTH-1:0]   r_mag_a;     // |multiplicand|
    logic [WIDTH-1:0]   r_mag_b;     // |multiplier| (shifts right) or |divisor|
    logic               r_neg_res;   // product / quotient must be negated
    logic               r_neg_rem;   // remainder must be negated
    logic               r_b_zero;    // accepted divide had a zero divisor
    logic [CNT_W-1:0]   r_cnt;       // RUN steps completed
    logic [2*WIDTH-1:0] r_acc;       // product; low half = dividend/quotient
    logic [WIDTH:0]     r_rem;       // restoring-division partial remainder
    logic               r_busy;
    logic               r_done;
    logic               r_div_zero;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    // ------------------------------------------------------------------------
    // Operand preparation (IDLE)
    // ------------------------------------------------------------------------
    logic             w_signed;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic             w_div_by_zero;

    assign w_signed      = ~op[0];
    assign w_a_neg       = w_signed & a[WIDTH-1];
    assign w_b_neg       = w_signed & b[WIDTH-1];
    // The magnitude of the most negative value is still representable as an
    // unsigned WIDTH-bit number, so the negation below needs no extra bit.
    assign w_abs_a       = w_a_neg ? -a : a;
    assign w_abs_b       = w_b_neg ? -b : b;
    assign w_div_by_zero = op[1] & (b == '0);

    // ------------------------------------------------------------------------
    // Multiply step: add the multiplicand into the upper half when the current
    // multiplier bit is set, then shift the whole accumulator right by one.
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] w_addend;
    logic [WIDTH:0]   w_msum;

    assign w_addend = r_mag_b[0] ? r_mag_a : '0;
    assign w_msum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, w_addend};

    // ------------------------------------------------------------------------
    // Divide step: shift the next dividend bit into the partial remainder and
    // trial-subtract the divisor. The remainder is always below the divisor,
    // so the shifted value fits in WIDTH+1 bits and a borrow shows up as the
    // top bit of the WIDTH+2 bit difference.
    // ------------------------------------------------------------------------
    logic [WIDTH+1:0] w_trial;
    logic             w_qbit;
    logic [WIDTH:0]   w_rem_next;

    assign w_trial    = {r_rem, r_acc[WIDTH-1]} - {2'b00, r_mag_b};
    assign w_qbit     = ~w_trial[WIDTH+1];
    assign w_rem_next = w_qbit ? w_trial[WIDTH:0]
                               : {r_rem[WIDTH-1:0], r_acc[WIDTH-1]};

    // ------------------------------------------------------------------------
    // RUN exit condition and product alignment
    // ------------------------------------------------------------------------
    logic               w_run_last;
    logic [2*WIDTH-1:0] w_prod_mag;

`ifdef MULDIV_EARLY_OUT_EN
    // Leave as soon as no set multiplier bits remain beyond the one being
    // consumed this cycle. The skipped steps would only have shifted the
    // accumulator right, so FIX applies that shift in one go.
    assign w_run_last = (r_cnt == c_CNT_LAST) ||
                        (!r_op[1] && (r_mag_b[WIDTH-1:1] == '0));
    assign w_prod_mag = r_acc >> (c_CNT_FULL - r_cnt);
`else
    assign w_run_last = (r_cnt == c_CNT_LAST);
    assign w_prod_mag = r_acc;
`endif

    // ------------------------------------------------------------------------
    // Sign correction (FIX)
    // ------------------------------------------------------------------------
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;

    assign w_prod_fix = r_neg_res ? -w_prod_mag : w_prod_mag;
    // MIN / -1: |q| = 2^(WIDTH-1) with a positive sign, which reads back as
    // MIN without any special casing.
    assign w_quo_fix  = r_neg_res ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_rem_fix  = r_neg_rem ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0];

    // ------------------------------------------------------------------------
    // Control FSM and datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_ST_IDLE;
            r_op       <= '0;
            r_mag_a    <= '0;
            r_mag_b    <= '0;
            r_neg_res  <= 1'b0;
            r_neg_rem  <= 1'b0;
            r_b_zero   <= 1'b0;
            r_cnt      <= '0;
            r_acc      <= '0;
            r_rem      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
        end else begin
            r_done <= 1'b0;

            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_op       <= op;
                        r_mag_a    <= w_abs_a;
                        r_mag_b    <= w_abs_b;
                        r_neg_res  <= w_a_neg ^ w_b_neg;
                        r_neg_rem  <= w_a_neg;
                        r_b_zero   <= w_div_by_zero;
                        r_cnt      <= '0;
                        r_rem      <= '0;
                        // Divide keeps the dividend in the low half; it is
                        // shifted out MSB-first while quotient bits shift in.
                        r_acc      <= op[1] ? {{WIDTH{1'b0}}, w_abs_a} : '0;
                        r_div_zero <= 1'b0;
                        r_busy     <= 1'b1;
                        // A zero divisor skips RUN; FIX only raises the flag.
                        r_state    <= w_div_by_zero ? c_ST_FIX : c_ST_RUN;
                    end
                end

                c_ST_RUN: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_op[1]) begin
                        r_rem              <= w_rem_next;
                        r_acc[WIDTH-1:0]   <= {r_acc[WIDTH-2:0], w_qbit};
                    end else begin
                        r_acc   <= {w_msum, r_acc[WIDTH-1:1]};
                        r_mag_b <= r_mag_b >> 1;
                    end
                    if (w_run_last) begin
                        r_state <= c_ST_FIX;
                    end
                end

                c_ST_FIX: begin
                    if (r_b_zero) begin
                        // hi/lo keep their previous contents.
                        r_div_zero <= 1'b1;
                    end else if (r_op[1]) begin
                        r_hi <= w_rem_fix;
                        r_lo <= w_quo_fix;
                    end else begin
                        r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod_fix[WIDTH-1:0];
                    end
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= c_ST_IDLE;
                end

                default: begin
                    r_busy  <= 1'b0;
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign busy     = r_busy;
    assign done     = r_done;
    assign div_zero = r_div_zero;
    assign hi       = r_hi;
    assign lo       = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_muldiv_seq
//  Description : Self-checking bench for muldiv_seq (WIDTH = 32). Directed
//                vectors from a table, a mid-operation reset sequence and
//                random operations checked against a 64-bit arithmetic model
//                through an expected-result queue.
//  Revision    : 1.0  initial release
// ============================================================================

module tb_muldiv_seq;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic         div_zero;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    always #5 clk = ~clk;

    muldiv_seq #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
    } exp_t;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
    } vec_t;

    exp_t         sbq[$];
    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] m_hi   = '0;
    logic [W-1:0] m_lo   = '0;

    function automatic void chk(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Reference model: plain 64-bit integer arithmetic.
    function automatic exp_t model(input logic [1:0] f_op, input logic [W-1:0] fa,
                                   input logic [W-1:0] fb);
        exp_t        e;
        longint      sa;
        longint      sbv;
        longint      q;
        longint      r;
        logic [63:0] p;
        e.hi = m_hi;
        e.lo = m_lo;
        e.dz = 1'b0;
        sa   = longint'($signed(fa));
        sbv  = longint'($signed(fb));
        case (f_op)
            2'd0: begin
                p = sa * sbv;
                e.hi = p[63:32];
                e.lo = p[31:0];
            end
            2'd1: begin
                p = {32'd0, fa} * {32'd0, fb};
                e.hi = p[63:32];
                e.lo = p[31:0];
            end
            2'd2: begin
                if (fb == '0) begin
                    e.dz = 1'b1;
                end else begin
                    q = sa / sbv;
                    r = sa % sbv;
                    e.lo = q[31:0];
                    e.hi = r[31:0];
                end
            end
            default: begin
                if (fb == '0) begin
                    e.dz = 1'b1;
                end else begin
                    p = {32'd0, fa} / {32'd0, fb};
                    e.lo = p[31:0];
                    p = {32'd0, fa} % {32'd0, fb};
                    e.hi = p[31:0];
                end
            end
        endcase
        return e;
    endfunction

    // One complete operation. poke > 0 re-asserts start (with other operands)
    // in the cycle after edge E<poke>; it must have no effect.
    task automatic run_op(input string tag, input logic [1:0] t_op,
                          input logic [W-1:0] ta, input logic [W-1:0] tb,
                          input exp_t e, input int poke);
        logic [W-1:0] snap_hi;
        logic [W-1:0] snap_lo;
        int           lat;
        int           exp_lat;
        logic         busy_bad;
        logic         hold_bad;
        exp_t         got;

        @(negedge clk);
        snap_hi = hi;
        snap_lo = lo;
        op      = t_op;
        a       = ta;
        b       = tb;
        start   = 1'b1;
        sbq.push_back(e);
        m_hi    = e.hi;
        m_lo    = e.lo;

        @(posedge clk);            // E0
        @(negedge clk);
        start = 1'b0;
        op    = 2'($urandom_range(0, 3));
        a     = $urandom;
        b     = $urandom;
        chk({tag, ".busy_start"}, 64'(busy), 64'd1);
        chk({tag, ".dz_clear"}, 64'(div_zero), 64'd0);

        lat      = 0;
        busy_bad = 1'b0;
        hold_bad = 1'b0;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk);        // En
            @(negedge clk);
            if (done) begin
                lat = n;
                break;
            end
            if (!busy) busy_bad = 1'b1;
            if (hi !== snap_hi || lo !== snap_lo) hold_bad = 1'b1;
            start = (n == poke);
            op    = 2'($urandom_range(0, 3));
            a     = $urandom;
            b     = $urandom;
        end
        start = 1'b0;

        got = sbq.pop_front();
        if (lat == 0) begin
            checks++;
            errors++;
            $display("FAIL %s.timeout: got no done expected done within 200 cycles", tag);
        end else begin
            chk({tag, ".busy_profile"}, 64'(busy_bad), 64'd0);
            chk({tag, ".hilo_hold"}, 64'(hold_bad), 64'd0);
            chk({tag, ".busy_done"}, 64'(busy), 64'd0);
            chk({tag, ".hi"}, 64'(hi), 64'(got.hi));
            chk({tag, ".lo"}, 64'(lo), 64'(got.lo));
            chk({tag, ".div_zero"}, 64'(div_zero), 64'(got.dz));
            if (got.dz) begin
                exp_lat = 1;
            end else if (t_op[1]) begin
                exp_lat = W + 1;
            end else begin
`ifdef MULDIV_EARLY_OUT_EN
                exp_lat = -1;
`else
                exp_lat = W + 1;
`endif
            end
            if (exp_lat > 0) chk({tag, ".latency"}, 64'(lat), 64'(exp_lat));
            @(negedge clk);
            chk({tag, ".done_pulse"}, 64'(done), 64'd0);
            chk({tag, ".dz_persist"}, 64'(div_zero), 64'(got.dz));
        end
    endtask

    vec_t vecs[12];

    initial begin
        exp_t         e;
        logic [1:0]   t_op;
        logic [W-1:0] ta;
        logic [W-1:0] tb;
        logic         no_done_bad;

        vecs[0]  = '{2'd0, 32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
        vecs[1]  = '{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
        vecs[2]  = '{2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0};
        vecs[3]  = '{2'd2, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
        vecs[4]  = '{2'd3, 32'hFFFF_FFF9, 32'd2,        32'h0000_0001, 32'h7FFF_FFFC, 1'b0};
        vecs[5]  = '{2'd1, 32'd5,         32'd6,        32'h0000_0000, 32'd30,        1'b0};
        vecs[6]  = '{2'd3, 32'd100,       32'd0,        32'h0000_0000, 32'd30,        1'b1};
        vecs[7]  = '{2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
        vecs[8]  = '{2'd2, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0};
        vecs[9]  = '{2'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
        vecs[10] = '{2'd2, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0003, 1'b0};
        vecs[11] = '{2'd2, 32'd5,         32'd0,        32'hFFFF_FFFF, 32'h0000_0003, 1'b1};

        // Reset state
        rst   = 1'b1;
        start = 1'b0;
        op    = '0;
        a     = '0;
        b     = '0;
        #1;
        chk("reset.busy", 64'(busy), 64'd0);
        chk("reset.done", 64'(done), 64'd0);
        chk("reset.div_zero", 64'(div_zero), 64'd0);
        chk("reset.hi", 64'(hi), 64'd0);
        chk("reset.lo", 64'(lo), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Directed table; the first entry also re-asserts start mid-run.
        for (int i = 0; i < 12; i++) begin
            e.hi = vecs[i].hi;
            e.lo = vecs[i].lo;
            e.dz = vecs[i].dz;
            run_op($sformatf("v%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, e,
                   (i == 0) ? 5 : 0);
        end

        // Reset in the middle of a MULT (hi/lo currently non-zero).
        @(negedge clk);
        op    = 2'd0;
        a     = 32'h1234_5678;
        b     = 32'h9ABC_DEF1;
        start = 1'b1;
        sbq.push_back(model(2'd0, 32'h1234_5678, 32'h9ABC_DEF1));
        @(posedge clk);
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            start = (n == 5);
        end
        start = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("midrst.busy", 64'(busy), 64'd0);
        chk("midrst.done", 64'(done), 64'd0);
        chk("midrst.hi", 64'(hi), 64'd0);
        chk("midrst.lo", 64'(lo), 64'd0);
        chk("midrst.div_zero", 64'(div_zero), 64'd0);
        sbq.delete();
        m_hi = '0;
        m_lo = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        no_done_bad = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (done || busy) no_done_bad = 1'b1;
        end
        chk("midrst.quiet", 64'(no_done_bad), 64'd0);
        e.hi = 32'd1;
        e.lo = 32'd2;
        e.dz = 1'b0;
        run_op("midrst.divu", 2'd3, 32'd9, 32'd4, e, 0);

        // Random operations against the model.
        for (int i = 0; i < 30; i++) begin
            t_op = 2'($urandom_range(0, 3));
            ta   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
            case ($urandom_range(0, 5))
                0:       tb = 32'($urandom_range(0, 2));
                1:       tb = 32'hFFFF_FFFF;
                2:       tb = 32'($urandom_range(1, 300));
                default: tb = $urandom;
            endcase
            e = model(t_op, ta, tb);
            run_op($sformatf("r%0d", i), t_op, ta, tb, e, (i % 7 == 3) ? 9 : 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
